// File: rtl/sarray_os_if.sv
// Operand, store-request and result bundle for the output-stationary systolic array.
// The array takes the slave view; the operand/store side takes the master view.
interface sarray_os_if #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int DW    = 8,
    parameter int AW    = 32,
    parameter int CNT_W = 8
);
    logic                left_in_valid_i;
    logic [CNT_W-1:0]    left_in_cnt_i;
    logic [ROWS*DW-1:0]  left_in_data_i;
    logic                top_in_valid_i;
    logic                top_in_acc_i;
    logic                top_in_precision_i;
    logic [CNT_W-1:0]    top_in_cnt_i;
    logic [COLS*DW-1:0]  top_in_data_i;
    logic                post_storec_valid_i;
    logic                in_ready_o;
    logic                err_o;
    logic                bot_o_valid_o;
    logic [CNT_W-1:0]    bot_o_cnt_o;
    logic [COLS*AW-1:0]  bot_o_data_o;

    modport master (
        output left_in_valid_i, left_in_cnt_i, left_in_data_i,
        output top_in_valid_i, top_in_acc_i, top_in_precision_i,
        output top_in_cnt_i, top_in_data_i, post_storec_valid_i,
        input  in_ready_o, err_o, bot_o_valid_o, bot_o_cnt_o, bot_o_data_o
    );

    modport slave (
        input  left_in_valid_i, left_in_cnt_i, left_in_data_i,
        input  top_in_valid_i, top_in_acc_i, top_in_precision_i,
        input  top_in_cnt_i, top_in_data_i, post_storec_valid_i,
        output in_ready_o, err_o, bot_o_valid_o, bot_o_cnt_o, bot_o_data_o
    );
endinterface

// File: rtl/sarray_os.sv
// Output-stationary ROWS x COLS MAC array with internal operand skew and a
// store-triggered flush/drain sequencer that shifts C out of the bottom row.
module sarray_os #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int DW    = 8,
    parameter int AW    = 32,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    sarray_os_if.slave bus
);
    localparam int FLUSH_LEN = ROWS + COLS;
    localparam int PH_W      = $clog2(FLUSH_LEN + 1);
    localparam logic [PH_W-1:0] FLUSH_LAST = PH_W'(FLUSH_LEN - 1);
    localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} state_t;

    // B element plus the per-beat controls that travel down its column.
    typedef struct packed {
        logic          valid;
        logic          prec;
        logic          acc;
        logic          first;
        logic [DW-1:0] data;
    } b_elem_t;

    state_t          state_reg, state_next;
    logic [PH_W-1:0] phase_reg, phase_next;
    logic            err_reg, err_next;
    logic            in_ready, beat_acc, store_acc, load_out;

    logic                bot_valid_reg;
    logic [CNT_W-1:0]    bot_cnt_reg;
    logic [COLS*AW-1:0]  bot_data_reg;
    logic [COLS*AW-1:0]  bot_row;

    logic [DW-1:0] a_edge [ROWS];
    b_elem_t       b_edge [COLS];
    logic [DW-1:0] a_out  [ROWS][COLS];
    b_elem_t       b_out  [ROWS][COLS];
    logic [AW-1:0] c_val  [ROWS][COLS];

    genvar gi, gj;

    // A row is captured and shifted into C in the same edge; no MACs are in flight then.
    always_comb begin
        in_ready  = (state_reg == IDLE) || (state_reg == COMPUTE);
        beat_acc  = in_ready && bus.left_in_valid_i && bus.top_in_valid_i;
        store_acc = in_ready && bus.post_storec_valid_i;
        load_out  = ((state_reg == FLUSH) && (phase_reg == FLUSH_LAST)) ||
                    ((state_reg == DRAIN) && (phase_reg != DRAIN_LAST));
    end

    always_comb begin
        state_next = state_reg;
        phase_next = phase_reg;
        err_next   = err_reg;
        if (in_ready && (bus.left_in_valid_i != bus.top_in_valid_i))
            err_next = 1'b1;
        if (beat_acc && (bus.left_in_cnt_i != bus.top_in_cnt_i))
            err_next = 1'b1;
        case (state_reg)
            IDLE, COMPUTE: begin
                if (store_acc) begin
                    state_next = FLUSH;
                    phase_next = '0;
                end else if (beat_acc) begin
                    state_next = COMPUTE;
                end
            end
            FLUSH: begin
                if (phase_reg == FLUSH_LAST) begin
                    state_next = DRAIN;
                    phase_next = '0;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            DRAIN: begin
                if (phase_reg == DRAIN_LAST) begin
                    state_next = IDLE;
                    phase_next = '0;
                end else begin
                    phase_next = phase_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            phase_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            phase_reg <= phase_next;
            err_reg   <= err_next;
        end
    end

    // Row r of A is delayed r+1 registers so it meets column-skewed B on the diagonal.
    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_askew
            logic [DW-1:0] line_reg [gi+1];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k <= gi; k++) line_reg[k] <= '0;
                end else begin
                    line_reg[0] <= beat_acc ? bus.left_in_data_i[gi*DW +: DW] : '0;
                    for (int k = 1; k <= gi; k++) line_reg[k] <= line_reg[k-1];
                end
            end
            assign a_edge[gi] = line_reg[gi];
        end

        for (gj = 0; gj < COLS; gj++) begin : g_bskew
            b_elem_t line_reg [gj+1];
            b_elem_t b_new;
            always_comb begin
                b_new       = '0;
                b_new.valid = beat_acc;
                b_new.prec  = bus.top_in_precision_i;
                b_new.acc   = bus.top_in_acc_i;
                b_new.first = (bus.top_in_cnt_i == '0);
                b_new.data  = bus.top_in_data_i[gj*DW +: DW];
            end
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 0; k <= gj; k++) line_reg[k] <= '0;
                end else begin
                    line_reg[0] <= b_new;
                    for (int k = 1; k <= gj; k++) line_reg[k] <= line_reg[k-1];
                end
            end
            assign b_edge[gj] = line_reg[gj];
        end
    endgenerate

    generate
        for (gi = 0; gi < ROWS; gi++) begin : g_row
            for (gj = 0; gj < COLS; gj++) begin : g_col
                logic [DW-1:0]         a_in;
                b_elem_t               b_in;
                logic [AW-1:0]         c_above;
                logic [DW-1:0]         a_reg;
                b_elem_t               b_reg;
                logic [AW-1:0]         c_reg;
                logic signed [DW:0]    a_x, b_x;
                logic signed [2*DW+1:0] prod;
                logic [AW-1:0]         prod_ext;

                if (gj == 0) begin : g_a_edge
                    assign a_in = a_edge[gi];
                end else begin : g_a_pass
                    assign a_in = a_out[gi][gj-1];
                end

                if (gi == 0) begin : g_b_edge
                    assign b_in    = b_edge[gj];
                    assign c_above = '0;
                end else begin : g_b_pass
                    assign b_in    = b_out[gi-1][gj];
                    assign c_above = c_val[gi-1][gj];
                end

                // One extra bit makes a single signed multiplier serve both precisions.
                always_comb begin
                    a_x      = {(b_in.prec ? 1'b0 : a_in[DW-1]), a_in};
                    b_x      = {(b_in.prec ? 1'b0 : b_in.data[DW-1]), b_in.data};
                    prod     = a_x * b_x;
                    prod_ext = AW'(prod);
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_reg <= '0;
                        b_reg <= '0;
                        c_reg <= '0;
                    end else begin
                        a_reg <= a_in;
                        b_reg <= b_in;
                        if (load_out)
                            c_reg <= c_above;
                        else if (b_in.valid)
                            c_reg <= (b_in.first && !b_in.acc) ? prod_ext : c_reg + prod_ext;
                    end
                end

                assign a_out[gi][gj] = a_reg;
                assign b_out[gi][gj] = b_reg;
                assign c_val[gi][gj] = c_reg;
            end
        end

        for (gj = 0; gj < COLS; gj++) begin : g_bot
            assign bot_row[gj*AW +: AW] = c_val[ROWS-1][gj];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bot_valid_reg <= 1'b0;
            bot_cnt_reg   <= '0;
            bot_data_reg  <= '0;
        end else if (load_out) begin
            bot_valid_reg <= 1'b1;
            bot_data_reg  <= bot_row;
            bot_cnt_reg   <= (state_reg == FLUSH) ? CNT_W'(ROWS - 1) : bot_cnt_reg - 1'b1;
        end else begin
            bot_valid_reg <= 1'b0;
            bot_cnt_reg   <= '0;
            bot_data_reg  <= '0;
        end
    end

    assign bus.in_ready_o    = in_ready;
    assign bus.err_o         = err_reg;
    assign bus.bot_o_valid_o = bot_valid_reg;
    assign bus.bot_o_cnt_o   = bot_cnt_reg;
    assign bus.bot_o_data_o  = bot_data_reg;
endmodule
